// File: rtl/wb_bram_pkg.sv
// -----------------------------------------------------------------------------
// wb_bram_pkg
// Shared definitions for the Wishbone-to-BRAM controller: FSM state encoding,
// parameter defaults, BRAM address width and small address helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package wb_bram_pkg;

   localparam int unsigned DELAYS_DEFAULT    = 10;
   localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h3800_0000;
   localparam int unsigned BRAM_AW           = 22;
   localparam int unsigned CNT_W             = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_ACK    = 2'd3
   } state_e;

   // The window is selected by the top address byte only.
   function automatic logic addr_hit(input logic [31:0] adr, input logic [31:0] base);
      return adr[31:24] == base[31:24];
   endfunction

   // BRAM byte address: low BRAM_AW bits of the bus address, zero-extended.
   function automatic logic [31:0] bram_addr(input logic [31:0] adr);
      return {{(32-BRAM_AW){1'b0}}, adr[BRAM_AW-1:0]};
   endfunction

endpackage

// File: rtl/wait_cnt.sv
// -----------------------------------------------------------------------------
// wait_cnt
// Down-counter that paces the wait cycles before a BRAM access.
//   clk_i       clock (rising edge)
//   rstn_i      synchronous active-low reset, clears the count
//   clr_i       clear the count (abort), highest priority
//   load_i      load load_val_i
//   load_val_i  value to load
//   dec_i       decrement by one (saturates at zero)
//   last_o      high while the count reads 1
// -----------------------------------------------------------------------------
module wait_cnt
   import wb_bram_pkg::*;
(
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             last_o
);

   logic [CNT_W-1:0] cnt_d, cnt_q;

   always_comb begin
      // NOTE: cnt_d gets a default before any branch so no path leaves it
      // unassigned; a missing default here would infer a latch.
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (!rstn_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/wb_bram_ctrl.sv
// -----------------------------------------------------------------------------
// wb_bram_ctrl
// Wishbone slave that maps a 16 MB window onto a single-port BRAM, inserting
// DELAYS wait cycles before each access. Accept-to-ack latency is DELAYS+2.
//   wb_clk_i, wb_rstn_i        clock, synchronous active-low reset
//   wbs_cyc_i/stb_i/we_i       Wishbone cycle, strobe, write enable
//   wbs_sel_i, wbs_adr_i       byte lanes, byte address
//   wbs_dat_i, wbs_dat_o       write data, read data
//   wbs_ack_o                  one-cycle transfer acknowledge
//   bram_en_o, bram_we_o       BRAM enable, per-byte write enable
//   bram_a_o, bram_di_o        BRAM byte address, write data
//   bram_do_i                  BRAM read data (valid the cycle after enable)
// -----------------------------------------------------------------------------
module wb_bram_ctrl
   import wb_bram_pkg::*;
#(
   parameter int unsigned DELAYS    = DELAYS_DEFAULT,
   parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
   input  logic        wb_clk_i,
   input  logic        wb_rstn_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        bram_en_o,
   output logic [3:0]  bram_we_o,
   output logic [31:0] bram_di_o,
   output logic [31:0] bram_a_o,
   input  logic [31:0] bram_do_i
);

   state_e      state_q;
   logic        we_q;
   logic [3:0]  sel_q;
   logic        ack_q;
   logic        en_q;
   logic [3:0]  bwe_q;
   logic [31:0] a_q;
   logic [31:0] di_q;
   logic        cnt_last;

   // Address bits between the BRAM range and the window byte select nothing.
   logic unused_adr;
   assign unused_adr = ^wbs_adr_i[31-8:BRAM_AW];

   logic req_hit;
   assign req_hit = wbs_cyc_i && wbs_stb_i && addr_hit(wbs_adr_i, BASE_ADDR);

   wait_cnt u_wait_cnt (
      .clk_i      (wb_clk_i),
      .rstn_i     (wb_rstn_i),
      .clr_i      ((state_q == ST_WAIT) && !wbs_cyc_i),
      .load_i     ((state_q == ST_IDLE) && req_hit && (DELAYS != 0)),
      .load_val_i (CNT_W'(DELAYS)),
      .dec_i      (state_q == ST_WAIT),
      .last_o     (cnt_last)
   );

   // Outputs are registered alongside the transition into the state that owns
   // them, so they are valid for exactly that state's cycle.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rstn_i) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         sel_q   <= '0;
         ack_q   <= 1'b0;
         en_q    <= 1'b0;
         bwe_q   <= '0;
         a_q     <= '0;
         di_q    <= '0;
      end else begin
         ack_q <= 1'b0;
         en_q  <= 1'b0;
         bwe_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (req_hit) begin
                  we_q  <= wbs_we_i;
                  sel_q <= wbs_sel_i;
                  a_q   <= bram_addr(wbs_adr_i);
                  di_q  <= wbs_dat_i;
                  if (DELAYS == 0) begin
                     state_q <= ST_ACCESS;
                     en_q    <= 1'b1;
                     bwe_q   <= wbs_we_i ? wbs_sel_i : 4'b0;
                  end else begin
                     state_q <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (!wbs_cyc_i) begin
                  state_q <= ST_IDLE;
               end else if (cnt_last) begin
                  state_q <= ST_ACCESS;
                  en_q    <= 1'b1;
                  bwe_q   <= we_q ? sel_q : 4'b0;
               end
            end
            ST_ACCESS: begin
               // The access itself is committed; only the ack depends on the
               // master still holding the cycle.
               state_q <= ST_ACK;
               ack_q   <= wbs_cyc_i;
            end
            ST_ACK: begin
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign wbs_ack_o = ack_q;
   assign bram_en_o = en_q;
   assign bram_we_o = bwe_q;
   assign bram_a_o  = a_q;
   assign bram_di_o = di_q;

   // BRAM read data arrives during the ack cycle itself, so it is gated
   // rather than registered; ack_q clears on reset, which zeroes this too.
   assign wbs_dat_o = (ack_q && !we_q) ? bram_do_i : 32'h0;

endmodule

// File: tb/tb_wb_bram_ctrl.sv
module tb_wb_bram_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        cyc_a, cyc_b, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat;

   logic        ack_a, en_a, ack_b, en_b;
   logic [3:0]  bwe_a, bwe_b;
   logic [31:0] dat_a, di_a, addr_a, do_a;
   logic [31:0] dat_b, di_b, addr_b, do_b;

   logic [31:0] mem_a [0:255];
   logic [31:0] mem_b [0:255];

   int tests = 0;
   int fails = 0;

   // Monitored DUT select and sampled transfer results
   bit          sel_dut;
   int          m_en_cnt, m_en_cyc, m_ack_cnt, m_ack_cyc;
   logic [3:0]  m_we_en, m_we_or;
   logic [31:0] m_a_en, m_di_en, m_rdata;

   always #5 clk = ~clk;

   wb_bram_ctrl #(.DELAYS(10), .BASE_ADDR(32'h3800_0000)) u_dut_a (
      .wb_clk_i(clk), .wb_rstn_i(rstn),
      .wbs_cyc_i(cyc_a), .wbs_stb_i(stb), .wbs_we_i(we),
      .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
      .wbs_ack_o(ack_a), .wbs_dat_o(dat_a),
      .bram_en_o(en_a), .bram_we_o(bwe_a), .bram_di_o(di_a), .bram_a_o(addr_a),
      .bram_do_i(do_a)
   );

   wb_bram_ctrl #(.DELAYS(0), .BASE_ADDR(32'h3800_0000)) u_dut_b (
      .wb_clk_i(clk), .wb_rstn_i(rstn),
      .wbs_cyc_i(cyc_b), .wbs_stb_i(stb), .wbs_we_i(we),
      .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
      .wbs_ack_o(ack_b), .wbs_dat_o(dat_b),
      .bram_en_o(en_b), .bram_we_o(bwe_b), .bram_di_o(di_b), .bram_a_o(addr_b),
      .bram_do_i(do_b)
   );

   // Behavioural BRAMs: registered read, byte writes, zero output when idle
   always @(posedge clk) begin
      if (en_a) begin
         for (int i = 0; i < 4; i++)
            if (bwe_a[i]) mem_a[addr_a[9:2]][i*8 +: 8] <= di_a[i*8 +: 8];
         do_a <= mem_a[addr_a[9:2]];
      end else begin
         do_a <= 32'h0;
      end
   end

   always @(posedge clk) begin
      if (en_b) begin
         for (int i = 0; i < 4; i++)
            if (bwe_b[i]) mem_b[addr_b[9:2]][i*8 +: 8] <= di_b[i*8 +: 8];
         do_b <= mem_b[addr_b[9:2]];
      end else begin
         do_b <= 32'h0;
      end
   end

   wire        ack_m = sel_dut ? ack_b : ack_a;
   wire        en_m  = sel_dut ? en_b  : en_a;
   wire [3:0]  bwe_m = sel_dut ? bwe_b : bwe_a;
   wire [31:0] a_m   = sel_dut ? addr_b : addr_a;
   wire [31:0] di_m  = sel_dut ? di_b  : di_a;
   wire [31:0] dat_m = sel_dut ? dat_b : dat_a;

   // Issue one request and watch ncyc cycles; cycle 1 is the cycle right
   // after the accepting edge. cyc drops after ack or after cycle drop_at.
   task automatic xfer(input bit dut, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input int drop_at, input int ncyc);
      m_en_cnt = 0; m_en_cyc = 0; m_ack_cnt = 0; m_ack_cyc = 0;
      m_we_en = '0; m_we_or = '0; m_a_en = '0; m_di_en = '0; m_rdata = '0;
      @(negedge clk);
      sel_dut = dut;
      cyc_a = !dut; cyc_b = dut; stb = 1'b1;
      we = wr; adr = a; dat = d; sel = s;
      @(posedge clk);
      for (int c = 1; c <= ncyc; c++) begin
         #1;
         m_we_or |= bwe_m;
         if (en_m) begin
            m_en_cnt++; m_en_cyc = c;
            m_we_en = bwe_m; m_a_en = a_m; m_di_en = di_m;
         end
         if (ack_m) begin
            m_ack_cnt++; m_ack_cyc = c; m_rdata = dat_m;
         end
         if (ack_m || c == drop_at) begin
            cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0;
         end
         if (c < ncyc) @(posedge clk);
      end
      cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      tests++;
      if ({ack_a, en_a, bwe_a, di_a, addr_a, dat_a} !== '0) begin
         fails++;
         $display("FAIL reset_a: ack=%b en=%b we=%h di=%h a=%h dat=%h, need all 0",
                  ack_a, en_a, bwe_a, di_a, addr_a, dat_a);
      end
      tests++;
      if ({ack_b, en_b, bwe_b, di_b, addr_b, dat_b} !== '0) begin
         fails++;
         $display("FAIL reset_b: ack=%b en=%b we=%h di=%h a=%h dat=%h, need all 0",
                  ack_b, en_b, bwe_b, di_b, addr_b, dat_b);
      end
   endtask

   task automatic test_write();
      xfer(1'b0, 1'b1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, -1, 16);
      tests++; if (m_en_cnt !== 1) begin fails++; $display("FAIL wr_en_count: got %0d need 1", m_en_cnt); end
      tests++; if (m_en_cyc !== 11) begin fails++; $display("FAIL wr_en_cycle: got %0d need 11", m_en_cyc); end
      tests++; if (m_we_en !== 4'hF) begin fails++; $display("FAIL wr_we: got %h need f", m_we_en); end
      tests++; if (m_a_en !== 32'h10) begin fails++; $display("FAIL wr_addr: got %h need 00000010", m_a_en); end
      tests++; if (m_di_en !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_di: got %h need deadbeef", m_di_en); end
      tests++; if (m_ack_cnt !== 1) begin fails++; $display("FAIL wr_ack_count: got %0d need 1", m_ack_cnt); end
      tests++; if (m_ack_cyc !== 12) begin fails++; $display("FAIL wr_ack_cycle: got %0d need 12", m_ack_cyc); end
      tests++; if (dat_a !== 32'h0) begin fails++; $display("FAIL wr_idle_dat: got %h need 0", dat_a); end
   endtask

   task automatic test_read();
      xfer(1'b0, 1'b0, 32'h3800_0010, 32'h0, 4'hF, -1, 16);
      tests++; if (m_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_data: got %h need deadbeef", m_rdata); end
      tests++; if (m_ack_cyc !== 12) begin fails++; $display("FAIL rd_ack_cycle: got %0d need 12", m_ack_cyc); end
      tests++; if (m_en_cyc !== 11) begin fails++; $display("FAIL rd_en_cycle: got %0d need 11", m_en_cyc); end
      tests++; if (m_we_or !== 4'h0) begin fails++; $display("FAIL rd_we_seen: got %h need 0", m_we_or); end
   endtask

   task automatic test_byte_lane();
      xfer(1'b0, 1'b1, 32'h3800_0010, 32'h00AA_0000, 4'b0100, -1, 16);
      tests++; if (m_we_en !== 4'b0100) begin fails++; $display("FAIL bl_we: got %b need 0100", m_we_en); end
      xfer(1'b0, 1'b0, 32'h3800_0010, 32'h0, 4'hF, -1, 16);
      tests++; if (m_rdata !== 32'hDEAA_BEEF) begin fails++; $display("FAIL bl_data: got %h need deaabeef", m_rdata); end
   endtask

   task automatic test_miss();
      xfer(1'b0, 1'b1, 32'h3000_0000, 32'h5555_5555, 4'hF, -1, 20);
      tests++; if (m_en_cnt !== 0) begin fails++; $display("FAIL miss_en: got %0d pulses need 0", m_en_cnt); end
      tests++; if (m_ack_cnt !== 0) begin fails++; $display("FAIL miss_ack: got %0d acks need 0", m_ack_cnt); end
   endtask

   task automatic test_abort();
      xfer(1'b0, 1'b1, 32'h3800_0010, 32'h1111_1111, 4'hF, 5, 20);
      tests++; if (m_en_cnt !== 0) begin fails++; $display("FAIL abort_en: got %0d pulses need 0", m_en_cnt); end
      tests++; if (m_ack_cnt !== 0) begin fails++; $display("FAIL abort_ack: got %0d acks need 0", m_ack_cnt); end
      xfer(1'b0, 1'b0, 32'h3800_0010, 32'h0, 4'hF, -1, 16);
      tests++; if (m_rdata !== 32'hDEAA_BEEF) begin fails++; $display("FAIL abort_next_data: got %h need deaabeef", m_rdata); end
      tests++; if (m_ack_cyc !== 12) begin fails++; $display("FAIL abort_next_ack: got %0d need 12", m_ack_cyc); end
   endtask

   task automatic test_zero_delay();
      xfer(1'b1, 1'b1, 32'h3800_0020, 32'h1234_5678, 4'hF, -1, 6);
      tests++; if (m_en_cyc !== 1) begin fails++; $display("FAIL z_en_cycle: got %0d need 1", m_en_cyc); end
      tests++; if (m_ack_cyc !== 2) begin fails++; $display("FAIL z_ack_cycle: got %0d need 2", m_ack_cyc); end
      xfer(1'b1, 1'b0, 32'h3800_0020, 32'h0, 4'hF, -1, 6);
      tests++; if (m_rdata !== 32'h1234_5678) begin fails++; $display("FAIL z_rd_data: got %h need 12345678", m_rdata); end
      tests++; if (m_ack_cyc !== 2) begin fails++; $display("FAIL z_rd_ack: got %0d need 2", m_ack_cyc); end
   endtask

   task automatic test_access_drop();
      xfer(1'b1, 1'b1, 32'h3800_0030, 32'hCAFE_F00D, 4'hF, 1, 6);
      tests++; if (m_en_cnt !== 1) begin fails++; $display("FAIL drop_en: got %0d pulses need 1", m_en_cnt); end
      tests++; if (m_ack_cnt !== 0) begin fails++; $display("FAIL drop_ack: got %0d acks need 0", m_ack_cnt); end
      xfer(1'b1, 1'b0, 32'h3800_0030, 32'h0, 4'hF, -1, 6);
      tests++; if (m_rdata !== 32'hCAFE_F00D) begin fails++; $display("FAIL drop_commit: got %h need cafef00d", m_rdata); end
   endtask

   task automatic test_reset_access();
      int bad = 0;
      @(negedge clk);
      sel_dut = 1'b1;
      cyc_b = 1'b1; stb = 1'b1; we = 1'b1;
      adr = 32'h3800_0040; dat = 32'hA5A5_A5A5; sel = 4'hF;
      @(posedge clk); #1;
      tests++; if (en_b !== 1'b1) begin fails++; $display("FAIL rst_pre_access: en=%b need 1", en_b); end
      rstn = 1'b0;
      @(posedge clk); #1;
      tests++;
      if ({ack_b, en_b, bwe_b, di_b, addr_b, dat_b} !== '0) begin
         fails++;
         $display("FAIL rst_in_access: ack=%b en=%b we=%h di=%h a=%h dat=%h, need all 0",
                  ack_b, en_b, bwe_b, di_b, addr_b, dat_b);
      end
      cyc_b = 1'b0; stb = 1'b0;
      @(negedge clk); rstn = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (ack_b || en_b) bad++;
      end
      tests++; if (bad !== 0) begin fails++; $display("FAIL rst_after: got %0d cycles with ack/en need 0", bad); end
   endtask

   initial begin
      rstn = 1'b0; cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0; we = 1'b0;
      sel = '0; adr = '0; dat = '0; sel_dut = 1'b0;
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 32'h0;
         mem_b[i] = 32'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk); rstn = 1'b1;
      @(negedge clk);
      test_write();
      test_read();
      test_byte_lane();
      test_miss();
      test_abort();
      test_zero_delay();
      test_access_drop();
      test_reset_access();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
